alu_exec_ctrl: RTL and testbench
================================

// Module: alu_exec_ctrl
// PURPOSE
// Parametrised successor to the MIPS ALU control decoder: decodes ALUOp (cntrlin) + funct into a
// 4-bit ALU code and executes the operation on WIDTH-bit operands with a valid/ready handshake.
// Single-cycle ops have 1-cycle latency; multiply is iterative shift-add (WIDTH cycles).
// Sits in EX, between ID/EX operands and the EX/MEM register.
// PARAMETERS
// WIDTH    32  operand/result width (>=8)
// SHAMT_W  5   shift-amount width; 2**SHAMT_W == WIDTH
// PORTS
// clk          in   1        clock, all state on rising edge
// rst          in   1        synchronous reset, active-high
// in_valid     in   1        operation offered
// in_ready     out  1        operation accepted on edge when in_valid&&in_ready
// cntrlin      in   2        ALUOp: 00 add, 01 sub, 10 use func, 11 or
// func         in   6        R-type funct field
// a, b         in   WIDTH    operands (rs, rt)
// shamt        in   SHAMT_W  shift amount
// out_valid    out  1        result available
// out_ready    in   1        result consumed on edge when out_valid&&out_ready
// result       out  WIDTH    low result
// result_hi    out  WIDTH    high product (mult), else 0
// alucntrlout  out  4        decoded ALU code, registered with result
// zero         out  1        result (full 2*WIDTH product for mult) == 0
// illegal      out  1        unsupported encoding
// BEHAVIOUR
// - Reset: state IDLE, out_valid=0, result=result_hi=0, alucntrlout=0, zero=0, illegal=0, counter=0;
//   reset mid-multiply aborts it, no output produced.
// - Decode: cntrlin 00->0010 add; 01->0110 sub; 11->0001 or; 10 by func: 100000/001000->0010 add,
//   100010->0110 sub, 100100->0000 and, 100101->0001 or, 100111->1100 nor, 101010->0111 slt,
//   000000->1000 sll(b<<shamt), 000010->1001 srl(b>>shamt logical), 011000->1010 mult.
//   Any other func: alucntrlout=1111, illegal=1, result=result_hi=0, zero=1, 1-cycle latency.
// - Arithmetic: add/sub wrap mod 2**WIDTH, no overflow flag; slt signed two's complement -> 0/1;
//   mult unsigned, {result_hi,result}=a*b.
// - FSM IDLE/MUL. in_ready = (state==IDLE) && (!out_valid || out_ready).
//   IDLE, accept non-mult: output regs loaded same edge, out_valid=1 next cycle.
//   IDLE, accept mult: latch a,b, acc=0, cnt=0 -> MUL. MUL: one multiplier bit per edge;
//   on edge with cnt==WIDTH-1 load outputs, out_valid=1, -> IDLE. Accept-to-out_valid = WIDTH cycles.
// - Output held stable while out_valid && !out_ready. Consume without accept: out_valid->0, data kept.
//   Consume + accept same edge: new non-mult result replaces old (throughput 1/cycle).
// - Invariant: one op in flight; output slot always empty when MUL completes, no stall in MUL.
// - in_valid ignored while in_ready=0; a, b, func need not be held after acceptance.
// TESTING
// 1 rst=1 2 cycles, then 0 -> out_valid=0, result=0, illegal=0, in_ready=1.
// 2 cntrlin=00 a=5 b=7 -> next cycle out_valid=1, result=12, alucntrlout=0010, zero=0;
//   cntrlin=01 a=b=9 -> result=0, zero=1.
// 3 func=101010 a=0xFFFFFFFF b=1 -> result=1; func=000010 b=0x80000000 shamt=31 -> result=1.
// 4 3 back-to-back adds, out_ready=0 for 2 cycles on first -> result held, in_ready=0,
//   all 3 delivered in order, none dropped/duplicated.
// 5 func=011000 a=0xFFFFFFFF b=2 -> in_ready=0 for 32 cycles, then result=0xFFFFFFFE,
//   result_hi=1, alucntrlout=1010.
// 6 func=111111 -> illegal=1, alucntrlout=1111, result=0; rst at cycle 10 of a mult ->
//   out_valid never rises, in_ready=1 after rst drops.

Source files
------------

// File: rtl/alu_exec_if.sv
// Handshake bundle between the ID/EX operand source and the EX-stage ALU controller.
// master drives the operation and consumes results; slave is the ALU.
interface alu_exec_if #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
);
   logic               in_valid;
   logic               in_ready;
   logic [1:0]         cntrlin;
   logic [5:0]         func;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic [SHAMT_W-1:0] shamt;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   result;
   logic [WIDTH-1:0]   result_hi;
   logic [3:0]         alucntrlout;
   logic               zero;
   logic               illegal;

   modport master (
      output in_valid, cntrlin, func, a, b, shamt, out_ready,
      input  in_ready, out_valid, result, result_hi, alucntrlout, zero, illegal
   );

   modport slave (
      input  in_valid, cntrlin, func, a, b, shamt, out_ready,
      output in_ready, out_valid, result, result_hi, alucntrlout, zero, illegal
   );
endinterface

// File: rtl/alu_exec_ctrl.sv
// EX-stage ALU: decodes ALUOp/funct into a 4-bit code and executes it behind a valid/ready
// handshake; single-cycle ops in one cycle, unsigned multiply by iterative shift-add.
module alu_exec_ctrl #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input logic      clk,
   input logic      rst,
   alu_exec_if.slave bus
);
   localparam int unsigned PROD_W = 2 * WIDTH;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;
   localparam logic [3:0] ALU_MULT = 4'b1010;
   localparam logic [3:0] ALU_NOR  = 4'b1100;
   localparam logic [3:0] ALU_ILL  = 4'b1111;

   typedef enum logic {IDLE, MUL} state_t;

   state_t             state;
   logic [PROD_W-1:0]  mul_acc;
   logic [PROD_W-1:0]  mul_mcand;
   logic [WIDTH-1:0]   mul_mplier;
   logic [SHAMT_W-1:0] cnt;

   logic [3:0]         code_c;
   logic               illegal_c;
   logic [WIDTH-1:0]   res_c;
   logic [PROD_W-1:0]  acc_next_c;
   logic               accept_c;

   // ALUOp/funct decode
   always_comb begin
      code_c    = ALU_ILL;
      illegal_c = 1'b0;
      unique case (bus.cntrlin)
         2'b00: code_c = ALU_ADD;
         2'b01: code_c = ALU_SUB;
         2'b11: code_c = ALU_OR;
         2'b10: begin
            case (bus.func)
               6'b100000, 6'b001000: code_c = ALU_ADD;
               6'b100010:            code_c = ALU_SUB;
               6'b100100:            code_c = ALU_AND;
               6'b100101:            code_c = ALU_OR;
               6'b100111:            code_c = ALU_NOR;
               6'b101010:            code_c = ALU_SLT;
               6'b000000:            code_c = ALU_SLL;
               6'b000010:            code_c = ALU_SRL;
               6'b011000:            code_c = ALU_MULT;
               default: begin
                  code_c    = ALU_ILL;
                  illegal_c = 1'b1;
               end
            endcase
         end
      endcase
   end

   // Single-cycle datapath; mult and illegal produce nothing here
   always_comb begin
      res_c = '0;
      case (code_c)
         ALU_ADD: res_c = bus.a + bus.b;
         ALU_SUB: res_c = bus.a - bus.b;
         ALU_AND: res_c = bus.a & bus.b;
         ALU_OR:  res_c = bus.a | bus.b;
         ALU_NOR: res_c = ~(bus.a | bus.b);
         ALU_SLT: res_c = WIDTH'($signed(bus.a) < $signed(bus.b));
         ALU_SLL: res_c = bus.b << bus.shamt;
         ALU_SRL: res_c = bus.b >> bus.shamt;
         default: res_c = '0;
      endcase
   end

   assign acc_next_c = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
   assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready);
   assign accept_c     = bus.in_valid && bus.in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         bus.out_valid   <= 1'b0;
         bus.result      <= '0;
         bus.result_hi   <= '0;
         bus.alucntrlout <= '0;
         bus.zero        <= 1'b0;
         bus.illegal     <= 1'b0;
         cnt             <= '0;
         mul_acc         <= '0;
         mul_mcand       <= '0;
         mul_mplier      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
               if (accept_c) begin
                  if (code_c == ALU_MULT) begin
                     mul_acc    <= '0;
                     mul_mcand  <= {{WIDTH{1'b0}}, bus.a};
                     mul_mplier <= bus.b;
                     cnt        <= '0;
                     state      <= MUL;
                  end else begin
                     bus.out_valid   <= 1'b1;
                     bus.result      <= res_c;
                     bus.result_hi   <= '0;
                     bus.alucntrlout <= code_c;
                     bus.illegal     <= illegal_c;
                     bus.zero        <= (res_c == '0);
                  end
               end
            end
            MUL: begin
               // One multiplier bit per edge; output slot is already empty here
               mul_acc    <= acc_next_c;
               mul_mcand  <= mul_mcand << 1;
               mul_mplier <= mul_mplier >> 1;
               cnt        <= cnt + SHAMT_W'(1);
               if (cnt == SHAMT_W'(WIDTH - 1)) begin
                  state           <= IDLE;
                  cnt             <= '0;
                  bus.out_valid   <= 1'b1;
                  bus.result      <= acc_next_c[WIDTH-1:0];
                  bus.result_hi   <= acc_next_c[PROD_W-1:WIDTH];
                  bus.alucntrlout <= ALU_MULT;
                  bus.illegal     <= 1'b0;
                  bus.zero        <= (acc_next_c == '0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: a transaction-level model predicts every output each cycle,
// and directed vectors with hand-computed values pin both the model and the DUT.
module tb_alu_exec_ctrl;
   localparam int unsigned W  = 32;
   localparam int unsigned SW = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_exec_if #(.WIDTH(W), .SHAMT_W(SW)) bus ();
   alu_exec_ctrl #(.WIDTH(W), .SHAMT_W(SW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;
   logic [31:0] delivered[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Operation semantics by name: plain arithmetic, full-width product for mult
   function automatic void model_op(input logic [1:0] c, input logic [5:0] f,
                                    input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                                    output logic [31:0] lo, output logic [31:0] hi,
                                    output logic [3:0] code, output logic ill,
                                    output logic zr, output logic mul);
      string op;
      logic [63:0] p;
      lo = '0; hi = '0; ill = 1'b0; mul = 1'b0; code = 4'hF;
      case (c)
         2'd0: op = "add";
         2'd1: op = "sub";
         2'd3: op = "or";
         default: case (f)
            6'h20, 6'h08: op = "add";
            6'h22: op = "sub";
            6'h24: op = "and";
            6'h25: op = "or";
            6'h27: op = "nor";
            6'h2A: op = "slt";
            6'h00: op = "sll";
            6'h02: op = "srl";
            6'h18: op = "mult";
            default: op = "bad";
         endcase
      endcase
      case (op)
         "add":  begin lo = a + b;        code = 4'b0010; end
         "sub":  begin lo = a - b;        code = 4'b0110; end
         "and":  begin lo = a & b;        code = 4'b0000; end
         "or":   begin lo = a | b;        code = 4'b0001; end
         "nor":  begin lo = ~(a | b);     code = 4'b1100; end
         "slt":  begin lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; code = 4'b0111; end
         "sll":  begin lo = b << sh;      code = 4'b1000; end
         "srl":  begin lo = b >> sh;      code = 4'b1001; end
         "mult": begin p = {32'd0, a} * {32'd0, b}; lo = p[31:0]; hi = p[63:32];
                       code = 4'b1010; mul = 1'b1; end
         default: begin ill = 1'b1; code = 4'b1111; end
      endcase
      zr = mul ? (p == 64'd0) : (lo == 32'd0);
   endfunction

   // Model state: what the output slot holds and how long a multiply has left
   logic        m_valid = 1'b0;
   logic [31:0] m_res = '0, m_hi = '0;
   logic [3:0]  m_code = '0;
   logic        m_zero = 1'b0, m_ill = 1'b0;
   int          m_busy = 0;
   logic [31:0] p_res, p_hi;
   logic [3:0]  p_code;
   logic        p_zero, p_ill, p_mul;

   always @(posedge clk) begin
      logic rdy;
      if (rst) begin
         m_valid = 1'b0; m_res = '0; m_hi = '0; m_code = '0;
         m_zero = 1'b0; m_ill = 1'b0; m_busy = 0;
      end else begin
         rdy = (m_busy == 0) && (!m_valid || bus.out_ready);
         if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin
               m_valid = 1'b1; m_res = p_res; m_hi = p_hi;
               m_code = p_code; m_zero = p_zero; m_ill = p_ill;
            end
         end else begin
            if (m_valid && bus.out_ready) m_valid = 1'b0;
            if (bus.in_valid && rdy) begin
               model_op(bus.cntrlin, bus.func, bus.a, bus.b, bus.shamt,
                        p_res, p_hi, p_code, p_ill, p_zero, p_mul);
               if (p_mul) begin
                  m_busy = W;
               end else begin
                  m_valid = 1'b1; m_res = p_res; m_hi = p_hi;
                  m_code = p_code; m_zero = p_zero; m_ill = p_ill;
               end
            end
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready",    bus.in_ready, (m_busy == 0) && (!m_valid || bus.out_ready));
         chk("out_valid",   bus.out_valid, m_valid);
         chk("result",      bus.result, m_res);
         chk("result_hi",   bus.result_hi, m_hi);
         chk("alucntrlout", bus.alucntrlout, m_code);
         chk("zero",        bus.zero, m_zero);
         chk("illegal",     bus.illegal, m_ill);
         if (bus.out_valid && bus.out_ready) delivered.push_back(bus.result);
      end
   end

   task automatic do_op(input logic [1:0] c, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
      int n = 0;
      bus.in_valid = 1'b1; bus.cntrlin = c; bus.func = f;
      bus.a = a; bus.b = b; bus.shamt = sh;
      @(negedge clk);
      while (!bus.in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) chk("accept_timeout", 64'd1, 64'd0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a = $urandom(); bus.b = $urandom(); bus.func = 6'($urandom());
   endtask

   task automatic wait_out(output int cycles);
      cycles = 0;
      @(negedge clk);
      while (!bus.out_valid && cycles < 100) begin
         cycles++;
         @(negedge clk);
      end
      if (cycles >= 100) chk("out_valid_timeout", 64'd1, 64'd0);
   endtask

   typedef struct {
      logic [1:0] c; logic [5:0] f; logic [31:0] a, b; logic [4:0] sh;
      logic [31:0] r, h; logic [3:0] code; logic z;
   } vec_t;
   vec_t vecs[$];

   initial begin
      int cyc, busy;
      bit seen;
      bus.in_valid = 1'b0; bus.cntrlin = '0; bus.func = '0;
      bus.a = '0; bus.b = '0; bus.shamt = '0; bus.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      chk_en = 1'b1;
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_result",    bus.result, 0);
      chk("rst_illegal",   bus.illegal, 0);
      chk("rst_in_ready",  bus.in_ready, 1);
      @(posedge clk); #1;

      vecs.push_back('{2'b00, 6'h00, 32'd5,        32'd7,        5'd0,  32'd12,       32'd0, 4'b0010, 1'b0});
      vecs.push_back('{2'b01, 6'h00, 32'd9,        32'd9,        5'd0,  32'd0,        32'd0, 4'b0110, 1'b1});
      vecs.push_back('{2'b10, 6'h2A, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd1,        32'd0, 4'b0111, 1'b0});
      vecs.push_back('{2'b10, 6'h02, 32'd0,        32'h80000000, 5'd31, 32'd1,        32'd0, 4'b1001, 1'b0});
      vecs.push_back('{2'b10, 6'h24, 32'h0000F0F0, 32'h0000FF00, 5'd0,  32'h0000F000, 32'd0, 4'b0000, 1'b0});
      vecs.push_back('{2'b10, 6'h27, 32'd0,        32'd0,        5'd0,  32'hFFFFFFFF, 32'd0, 4'b1100, 1'b0});
      vecs.push_back('{2'b10, 6'h00, 32'd0,        32'd1,        5'd4,  32'd16,       32'd0, 4'b1000, 1'b0});
      vecs.push_back('{2'b11, 6'h3F, 32'h0000000F, 32'h000000F0, 5'd0,  32'h000000FF, 32'd0, 4'b0001, 1'b0});
      vecs.push_back('{2'b10, 6'h20, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd0,        32'd0, 4'b0010, 1'b1});
      vecs.push_back('{2'b10, 6'h08, 32'd3,        32'd4,        5'd0,  32'd7,        32'd0, 4'b0010, 1'b0});
      vecs.push_back('{2'b10, 6'h18, 32'h00010000, 32'h00010000, 5'd0,  32'd0,        32'd1, 4'b1010, 1'b0});
      vecs.push_back('{2'b10, 6'h18, 32'd0,        32'd5,        5'd0,  32'd0,        32'd0, 4'b1010, 1'b1});

      foreach (vecs[i]) begin
         do_op(vecs[i].c, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].sh);
         wait_out(cyc);
         chk($sformatf("vec%0d_result", i), bus.result, vecs[i].r);
         chk($sformatf("vec%0d_hi", i),     bus.result_hi, vecs[i].h);
         chk($sformatf("vec%0d_code", i),   bus.alucntrlout, vecs[i].code);
         chk($sformatf("vec%0d_zero", i),   bus.zero, vecs[i].z);
         @(posedge clk); #1;
      end

      // Three back-to-back adds with the first result stalled for two cycles
      repeat (2) @(posedge clk);
      #1 delivered.delete();
      bus.out_ready = 1'b0;
      do_op(2'b00, 6'h00, 32'd1, 32'd2, 5'd0);
      fork
         begin
            do_op(2'b00, 6'h00, 32'd3, 32'd4, 5'd0);
            do_op(2'b00, 6'h00, 32'd5, 32'd6, 5'd0);
         end
         begin
            repeat (2) begin
               @(negedge clk);
               chk("stall_result",   bus.result, 32'd3);
               chk("stall_in_ready", bus.in_ready, 0);
            end
            @(posedge clk); #1 bus.out_ready = 1'b1;
         end
      join
      repeat (3) @(posedge clk);
      #1;
      chk("b2b_count", 64'(delivered.size()), 64'd3);
      if (delivered.size() == 3) begin
         chk("b2b_0", delivered[0], 32'd3);
         chk("b2b_1", delivered[1], 32'd7);
         chk("b2b_2", delivered[2], 32'd11);
      end

      // Multiply latency and high word
      do_op(2'b10, 6'h18, 32'hFFFFFFFF, 32'd2, 5'd0);
      busy = 0;
      cyc = 0;
      @(negedge clk);
      while (!bus.out_valid && cyc < 100) begin
         if (!bus.in_ready) busy++;
         cyc++;
         @(negedge clk);
      end
      chk("mult_busy_cycles", 64'(busy), 64'd32);
      chk("mult_result",      bus.result, 32'hFFFFFFFE);
      chk("mult_hi",          bus.result_hi, 32'd1);
      chk("mult_code",        bus.alucntrlout, 4'b1010);
      @(posedge clk); #1;

      // Illegal funct
      do_op(2'b10, 6'h3F, 32'd1, 32'd2, 5'd0);
      @(negedge clk);
      chk("ill_flag",   bus.illegal, 1);
      chk("ill_code",   bus.alucntrlout, 4'b1111);
      chk("ill_result", bus.result, 0);
      chk("ill_zero",   bus.zero, 1);
      @(posedge clk); #1;

      // Reset aborts a multiply in flight
      do_op(2'b10, 6'h18, 32'd7, 32'd9, 5'd0);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      seen = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", bus.in_ready, 1);
      repeat (40) begin
         if (bus.out_valid) seen = 1'b1;
         @(negedge clk);
      end
      chk("abort_no_output", 64'(seen), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
